addsub_share_arbiter: RTL and testbench

- Shares one external WIDTH-bit ripple-carry adder/subtractor between two requesters.
- Arbitrates requests round-robin, registers the operands, and drives the shared unit.
- Captures its sum and carry, then returns the result to the winning requester over a valid/ready response channel.
- One operation in flight at a time. Sits between the client logic and the shared add/sub datapath.

---
 rtl/addsub_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_addsub_share_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter
//   Shares one external WIDTH-bit add/subtract unit between two requesters.
//   A round-robin grant picks one request in IDLE, its operands are
//   registered and drive the shared unit for one EXEC cycle, the unit's
//   sum/carry are captured, and the result is returned to the owner over a
//   valid/ready response channel (RESP). Only one operation is in flight.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   reqN_valid/ready         request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_sub operands and op select (1 = A-B)
//   respN_valid/ready        response handshake
//   respN_s, respN_cout      result and carry (0 while respN_valid is low)
//   au_a, au_b, au_con       operands/control driven to the shared unit
//   au_s, au_cout            combinational result from the shared unit
//
// Optional build macro ADDSUB_SHARE_ARBITER_OVF_EN adds respN_ovf, the
// two's-complement signed overflow of the returned result.

module addsub_share_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_s,
  output logic             resp0_cout,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_s,
  output logic             resp1_cout,
`ifdef ADDSUB_SHARE_ARBITER_OVF_EN
  output logic             resp0_ovf,
  output logic             resp1_ovf,
`endif
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic             au_con,
  input  logic [WIDTH-1:0] au_s,
  input  logic             au_cout
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  // Requester-indexed views of the two request/response channels.
  logic [1:0][WIDTH-1:0] req_a, req_b;
  logic [1:0]            req_sub, req_vld, resp_rdy, resp_vld;

  assign req_a    = {req1_a, req0_a};
  assign req_b    = {req1_b, req0_b};
  assign req_sub  = {req1_sub, req0_sub};
  assign req_vld  = {req1_valid, req0_valid};
  assign resp_rdy = {resp1_ready, resp0_ready};

  logic [WIDTH-1:0] op_a, op_b, res_s;
  logic             op_sub, res_cout, owner, ptr;
  logic             win, any_req, acc, fire;

  // Winner: the sole valid requester, or the pointer when both are valid.
  // With no request pending there is no winner and neither ready asserts.
  always_comb begin
    any_req = |req_vld;
    win     = (&req_vld) ? ptr : req_vld[1];
    acc     = (state == IDLE) && any_req;
    fire    = (state == RESP) && resp_rdy[owner];
  end

  assign req0_ready = acc && !win;
  assign req1_ready = acc &&  win;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc)  state_nxt = EXEC;
      EXEC:              state_nxt = RESP;
      RESP:    if (fire) state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

`ifdef ADDSUB_SHARE_ARBITER_OVF_EN
  logic res_ovf, ovf_nxt;

  // Subtract overflows when the operand signs differ (B is effectively
  // negated); add when they match. Either way the result sign flips from A.
  always_comb begin
    ovf_nxt = (au_s[MSB] != op_a[MSB]) &&
              (op_sub ? (op_a[MSB] != op_b[MSB]) : (op_a[MSB] == op_b[MSB]));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      op_sub   <= 1'b0;
      owner    <= 1'b0;
      ptr      <= 1'b0;
      res_s    <= '0;
      res_cout <= 1'b0;
`ifdef ADDSUB_SHARE_ARBITER_OVF_EN
      res_ovf  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (acc) begin
        op_a   <= req_a[win];
        op_b   <= req_b[win];
        op_sub <= req_sub[win];
        owner  <= win;
        ptr    <= ~win;
      end
      if (state == EXEC) begin
        res_s    <= au_s;
        res_cout <= au_cout;
`ifdef ADDSUB_SHARE_ARBITER_OVF_EN
        res_ovf  <= ovf_nxt;
`endif
      end
    end
  end

  // Operand registers drive the shared unit continuously.
  assign au_a   = op_a;
  assign au_b   = op_b;
  assign au_con = op_sub;

  genvar n;
  generate
    for (n = 0; n < 2; n++) begin : g_resp
      assign resp_vld[n] = (state == RESP) && (owner == 1'(n));
    end
  endgenerate

  // Response data is gated so the non-owner channel reads 0.
  assign resp0_valid = resp_vld[0];
  assign resp1_valid = resp_vld[1];
  assign resp0_s     = resp_vld[0] ? res_s : '0;
  assign resp1_s     = resp_vld[1] ? res_s : '0;
  assign resp0_cout  = resp_vld[0] && res_cout;
  assign resp1_cout  = resp_vld[1] && res_cout;
`ifdef ADDSUB_SHARE_ARBITER_OVF_EN
  assign resp0_ovf   = resp_vld[0] && res_ovf;
  assign resp1_ovf   = resp_vld[1] && res_ovf;
`endif

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Bench for addsub_share_arbiter: directed cases followed by randomized
// operations, checked against arithmetic expectations and a transaction-level
// round-robin pointer. Also models the external shared add/sub unit.
// Define ADDSUB_SHARE_ARBITER_OVF_EN for both files to cover respN_ovf.

module tb_addsub_share_arbiter;

  localparam int W = 3;
  localparam int MOD = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0, rst = 1'b1;
  logic         req0_valid = 0, req1_valid = 0, req0_sub = 0, req1_sub = 0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_ready, req1_ready;
  logic         resp0_valid, resp1_valid, resp0_cout, resp1_cout;
  logic         resp0_ready = 0, resp1_ready = 0;
  logic [W-1:0] resp0_s, resp1_s;
  logic [W-1:0] au_a, au_b, au_s;
  logic         au_con, au_cout;
  logic [W:0]   au_full;
`ifdef ADDSUB_SHARE_ARBITER_OVF_EN
  logic         resp0_ovf, resp1_ovf;
`endif

  int nchecks = 0, nerr = 0;
  bit ptr_m = 0;

  always #5 clk = ~clk;

  // External shared ripple-carry add/subtract unit.
  assign au_full = au_con ? ({1'b0, au_a} + {1'b0, ~au_b} + (W+1)'(1))
                          : ({1'b0, au_a} + {1'b0, au_b});
  assign au_s    = au_full[W-1:0];
  assign au_cout = au_full[W];

  addsub_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_s(resp0_s),
    .resp0_cout(resp0_cout),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_s(resp1_s),
    .resp1_cout(resp1_cout),
`ifdef ADDSUB_SHARE_ARBITER_OVF_EN
    .resp0_ovf(resp0_ovf), .resp1_ovf(resp1_ovf),
`endif
    .au_a(au_a), .au_b(au_b), .au_con(au_con), .au_s(au_s), .au_cout(au_cout)
  );

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", nchecks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full transaction: arbitration, EXEC, RESP with `stall` cycles of
  // back-pressure. With hold_other, the losing side raises valid during the
  // stall and must be refused until the channel is free again.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input bit s0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input bit s1,
                        input int stall, input bit hold_other);
    bit w, es_c;
    int ia, ib, r, sa, sb, sr;
    logic [W-1:0] ea, eb, es;
    bit esub, eovf;
    w = (v0 && v1) ? ptr_m : v1;
    ea = w ? a1 : a0; eb = w ? b1 : b0; esub = w ? s1 : s0;
    ia = int'(ea); ib = int'(eb);
    r  = esub ? (ia - ib + MOD) : (ia + ib);
    es = W'(r % MOD);
    es_c = esub ? (ia >= ib) : (ia + ib >= MOD);
    sa = (ia >= HALF) ? ia - MOD : ia;
    sb = (ib >= HALF) ? ib - MOD : ib;
    sr = esub ? sa - sb : sa + sb;
    eovf = (sr >= HALF) || (sr < -HALF);

    // Owner's response ready starts low; the other side's is random noise.
    if (w) begin resp1_ready = 0; resp0_ready = 1'($urandom); end
    else   begin resp0_ready = 0; resp1_ready = 1'($urandom); end
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    #1;
    chk("req0_ready", req0_ready, 32'(w == 0));
    chk("req1_ready", req1_ready, 32'(w == 1));
    tick();
    ptr_m = ~w;
    req0_valid = 0; req1_valid = 0;
    chk("exec_au_a", au_a, ea);
    chk("exec_au_b", au_b, eb);
    chk("exec_au_con", au_con, esub);
    chk("exec_rdy", {req1_ready, req0_ready}, 0);
    chk("exec_vld", {resp1_valid, resp0_valid}, 0);
    tick();
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) begin
        if (hold_other) begin
          if (w) req0_valid = 1; else req1_valid = 1;
          #1;
          chk("stall_other_rdy", w ? req0_ready : req1_ready, 0);
        end
        tick();
      end
      chk("resp_valid", w ? resp1_valid : resp0_valid, 1);
      chk("resp_s", w ? resp1_s : resp0_s, es);
      chk("resp_cout", w ? resp1_cout : resp0_cout, es_c);
`ifdef ADDSUB_SHARE_ARBITER_OVF_EN
      chk("resp_ovf", w ? resp1_ovf : resp0_ovf, eovf);
      chk("other_ovf", w ? resp0_ovf : resp1_ovf, 0);
`endif
      chk("other_resp", w ? {resp0_valid, resp0_s, resp0_cout}
                          : {resp1_valid, resp1_s, resp1_cout}, 0);
    end
    if (w) resp1_ready = 1; else resp0_ready = 1;
    tick();
    resp0_ready = 0; resp1_ready = 0;
    chk("resp_done", {resp1_valid, resp0_valid}, 0);
    if (hold_other && stall > 0) begin
      #1;
      chk("other_rdy_after", w ? req0_ready : req1_ready, 1);
    end
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_outs", {req0_ready, req1_ready, resp0_valid, resp1_valid,
                     resp0_s, resp1_s, resp0_cout, resp1_cout}, 0);
    chk("rst_au", {au_a, au_b, au_con}, 0);
    repeat (2) tick();
    rst = 0;
    tick();

    // Directed arithmetic cases.
    run_op(1, 0, 3'd3, 3'd2, 0, 3'd0, 3'd0, 0, 0, 0);  // 3+2 = 5, c0
    run_op(1, 0, 3'd7, 3'd1, 0, 3'd0, 3'd0, 0, 1, 0);  // 7+1 = 0, c1
    run_op(0, 1, 3'd0, 3'd0, 0, 3'd1, 3'd3, 1, 0, 0);  // 1-3 = 6, c0
    run_op(0, 1, 3'd0, 3'd0, 0, 3'd4, 3'd0, 1, 2, 0);  // 4-0 = 4, c1
    run_op(1, 0, 3'd3, 3'd1, 0, 3'd0, 3'd0, 0, 0, 0);  // 3+1 signed ovf
    run_op(1, 0, 3'd4, 3'd1, 1, 3'd0, 3'd0, 0, 0, 0);  // 4-1 signed ovf
    run_op(0, 1, 3'd0, 3'd0, 0, 3'd1, 3'd1, 0, 0, 0);  // 1+1 no ovf

    // Back-pressure on resp0 with req1 waiting.
    run_op(1, 0, 3'd6, 3'd5, 0, 3'd0, 3'd0, 0, 5, 1);
    run_op(0, 1, 3'd0, 3'd0, 0, 3'd2, 3'd6, 1, 0, 0);

    // Reset mid-operation, after req0 won (pointer moved to req1).
    rst = 1; tick(); rst = 0; ptr_m = 0; tick();
    req0_valid = 1; req0_a = 3'd5; req0_b = 3'd6; req0_sub = 1;
    tick();
    req0_valid = 0;
    chk("pre_rst_exec_au_a", au_a, 3'd5);
    rst = 1;
    #1;
    chk("midrst_outs", {req0_ready, req1_ready, resp0_valid, resp1_valid,
                        resp0_s, resp1_s, resp0_cout, resp1_cout}, 0);
    chk("midrst_au", {au_a, au_b, au_con}, 0);
    tick();
    rst = 0;
    ptr_m = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_resp", {resp1_valid, resp0_valid}, 0);
    end

    // Contention after reset: req0 first, then alternation.
    for (int i = 0; i < 4; i++)
      run_op(1, 1, W'($urandom), W'($urandom), 1'($urandom),
             W'($urandom), W'($urandom), 1'($urandom), 0, 0);

    // Randomized operations.
    for (int k = 0; k < 40; k++) begin
      int pat;
      pat = $urandom_range(1, 3);
      run_op(pat[0], pat[1], W'($urandom), W'($urandom), 1'($urandom),
             W'($urandom), W'($urandom), 1'($urandom),
             $urandom_range(0, 3), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
